uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART transmit line between NUM_REQ byte requesters. Round-robin
//  arbitration picks a requester, latches its byte and serialises it as an 8N1
//  frame (optionally 8E1), advancing one bit per txclk_en tick from the baud
//  rate generator. Sits between the command/status sources and the TX pin.
// PARAMETERS
//  NUM_REQ   4   number of requesters, 2..8
//  DATA_W    8   data bits per frame, LSB first
// PORTS
//  clk_50m   in   1                system clock, 50 MHz
//  rst       in   1                reset, asynchronous, active-high
//  txclk_en  in   1                1-cycle bit tick from the baud rate generator
//  req       in   NUM_REQ          per-requester transmit request, level
//  req_data  in   NUM_REQ*DATA_W   byte of requester i at [i*DATA_W +: DATA_W]
//  ack       out  NUM_REQ          1-cycle pulse: byte of requester i latched
//  grant_id  out  $clog2(NUM_REQ)  index of requester owning the current frame
//  busy      out  1                frame in progress (START..STOP)
//  tx        out  1                serial output, idle high, registered
// BEHAVIOUR
//  - Reset (async): tx=1, ack=0, busy=0, grant_id=0, state=IDLE, rr_ptr=0,
//    bit counter=0. Reset mid-frame aborts it; tx returns to 1 at once, no ack
//    is re-issued, aborted requester must still hold req to be served later.
//  - States IDLE, START, DATA, [PARITY], STOP. All changes happen only on a
//    clk_50m edge where txclk_en=1; otherwise every register holds (ack is 0).
//  - Arbitration on a tick in IDLE or at the end of STOP: if any req is high,
//    winner = first set req scanning from rr_ptr upward, modulo NUM_REQ.
//    Same edge: latch req_data slice, ack[winner]=1 for one cycle,
//    grant_id=winner, rr_ptr=winner+1 (wraps NUM_REQ-1 -> 0), tx=0, busy=1,
//    state=START. No req: tx=1, busy=0, state=IDLE.
//  - START tick: tx=data[0], cnt=0, state=DATA. DATA tick: cnt<DATA_W-1 ->
//    tx=data[cnt+1], cnt++; cnt=DATA_W-1 -> state=STOP (or PARITY), tx=1
//    (or parity bit). PARITY tick: tx=1, state=STOP.
//  - STOP holds tx=1 for one full bit; its ending tick re-arbitrates, so
//    back-to-back frames have no extra idle bit.
//  - Frame latency: ack to first stop-bit end = (DATA_W+2) ticks
//    (434 cycles each at 50 MHz/115200).
//  - Handshake: requester holds req and req_data stable until ack; may
//    present next byte in the cycle after ack. Dropping req before ack
//    withdraws the request without side effects. req_data changes after ack
//    do not affect the frame in flight.
//  - Simultaneous reqs: exactly one ack per frame; with all reqs held high
//    grant order is strictly rr_ptr, rr_ptr+1, ... (no starvation).
//  - txclk_en in the same cycle as rst deassertion is ignored.
// CONFIGURATION
//  UART_TX_ARB_PARITY_EN defined: even-parity bit (XOR of data) sent after
//    the last data bit via PARITY state; frame = DATA_W+3 ticks.
//  Not defined: PARITY state absent, 8N1 frame = DATA_W+2 ticks.
// TESTING
//  1. req[0]=1, data 0x55, ticks every 434 cycles -> ack[0] one pulse; tx =
//     0,1,0,1,0,1,0,1,0,1 per tick; busy falls at stop end; tx stays 1.
//  2. req[1] and req[2] rise together, data 0xA1/0x3C -> ack[1] then ack[2];
//     frames back-to-back with no idle bit; grant_id 1 then 2.
//  3. All four reqs held high for 8 frames -> grant order 0,1,2,3,0,1,2,3.
//  4. rst pulse during DATA bit 3 of 0xF0 -> tx=1 in same cycle, busy=0,
//     ack=0; after release req held -> full 0xF0 frame resent, rr_ptr=0.
//  5. req[3] raised then dropped before any tick -> no ack, tx stays 1.
//  6. With UART_TX_ARB_PARITY_EN, data 0x07 -> parity bit 1, 11-tick frame;
//     data 0x03 -> parity bit 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART TX line between NUM_REQ byte requesters.
// Round-robin arbitration picks a requester, latches its byte and shifts an
// 8N1 frame out LSB first, one bit per txclk_en tick.
// Optional feature macro: UART_TX_ARB_PARITY_EN adds an even-parity bit
// between the last data bit and the stop bit (8E1).
module uart_tx_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8
) (
   input  logic                       clk_50m,
   input  logic                       rst,
   input  logic                       txclk_en,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*DATA_W-1:0]  req_data,
   output logic [NUM_REQ-1:0]         ack,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       busy,
   output logic                       tx
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef UART_TX_ARB_PARITY_EN
   localparam logic [2:0] ST_PARITY = 3'd4;
`endif

   logic [2:0]        state;
   logic [IW-1:0]     rr_ptr;
   logic [IW-1:0]     winner;
   logic [IW-1:0]     next_ptr;
   logic [CW-1:0]     cnt;
   logic [DATA_W-1:0] data_q;
   logic              armed;
   logic              any_req;
   logic              tick;
   int                best_off;
   int                off;

   // A tick on the first edge after reset release is dropped: armed is still 0.
   assign tick = txclk_en & armed;

   // Round-robin pick: requester with the smallest distance upward from rr_ptr.
   always_comb begin
      any_req  = 1'b0;
      winner   = '0;
      best_off = NUM_REQ;
      off      = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         off = i - int'(rr_ptr);
         if (off < 0) off = off + NUM_REQ;
         if (req[i] && (off < best_off)) begin
            best_off = off;
            winner   = IW'(i);
            any_req  = 1'b1;
         end
      end
   end

   assign next_ptr = (winner == IW'(NUM_REQ-1)) ? '0 : winner + 1'b1;

   // Frame sequencer: everything advances only on an accepted tick; ack is a one-cycle pulse.
   always_ff @(posedge clk_50m or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         rr_ptr   <= '0;
         cnt      <= '0;
         data_q   <= '0;
         ack      <= '0;
         grant_id <= '0;
         busy     <= 1'b0;
         tx       <= 1'b1;
         armed    <= 1'b0;
      end else begin
         armed <= 1'b1;
         ack   <= '0;
         if (tick) begin
            case (state)
               // Idle and the end of a stop bit share one arbitration point, so
               // back-to-back frames need no extra idle bit.
               ST_IDLE, ST_STOP: begin
                  if (any_req) begin
                     data_q      <= req_data[winner*DATA_W +: DATA_W];
                     ack[winner] <= 1'b1;
                     grant_id    <= winner;
                     rr_ptr      <= next_ptr;
                     tx          <= 1'b0;
                     busy        <= 1'b1;
                     state       <= ST_START;
                  end else begin
                     tx    <= 1'b1;
                     busy  <= 1'b0;
                     state <= ST_IDLE;
                  end
               end
               ST_START: begin
                  tx    <= data_q[0];
                  cnt   <= '0;
                  state <= ST_DATA;
               end
               ST_DATA: begin
                  if (cnt == CW'(DATA_W-1)) begin
`ifdef UART_TX_ARB_PARITY_EN
                     tx    <= ^data_q;
                     state <= ST_PARITY;
`else
                     tx    <= 1'b1;
                     state <= ST_STOP;
`endif
                  end else begin
                     tx  <= data_q[cnt + 1'b1];
                     cnt <= cnt + 1'b1;
                  end
               end
`ifdef UART_TX_ARB_PARITY_EN
               ST_PARITY: begin
                  tx    <= 1'b1;
                  state <= ST_STOP;
               end
`endif
               default: begin
                  tx    <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed table, hand-written corner sequences and random
// traffic, all cross-checked every cycle against a frame-queue reference model.
// Honours UART_TX_ARB_PARITY_EN the same way as the design.
module tb_uart_tx_arbiter;

   localparam int NREQ = 4;
   localparam int DW   = 8;
`ifdef UART_TX_ARB_PARITY_EN
   localparam int NB = DW + 3;
`else
   localparam int NB = DW + 2;
`endif

   logic                 clk_50m = 1'b0;
   logic                 rst = 1'b1;
   logic                 txclk_en = 1'b0;
   logic [NREQ-1:0]      req = '0;
   logic [NREQ*DW-1:0]   req_data = '0;
   logic [NREQ-1:0]      ack;
   logic [1:0]           grant_id;
   logic                 busy;
   logic                 tx;

   uart_tx_arbiter #(.NUM_REQ(NREQ), .DATA_W(DW)) dut (
      .clk_50m  (clk_50m),
      .rst      (rst),
      .txclk_en (txclk_en),
      .req      (req),
      .req_data (req_data),
      .ack      (ack),
      .grant_id (grant_id),
      .busy     (busy),
      .tx       (tx)
   );

   always #10 clk_50m = ~clk_50m;

   int checks = 0;
   int errors = 0;

   // reference model: queue of bits still to be sent after the current one
   bit              mq[$];
   int              m_rr;
   logic            m_busy, m_tx, m_armed;
   logic [NREQ-1:0] m_ack;
   logic [1:0]      m_gid;

   // observations
   int          grant_log[$];
   logic [63:0] tick_vec;
   int          tick_n;
   bit          auto_drop;

   typedef struct {
      logic [3:0] r;
      logic [7:0] d0;
      logic [7:0] d3;
      logic       tk;
      logic       etx;
      logic       ebusy;
      logic [3:0] eack;
      logic [1:0] egid;
   } vec_t;
   vec_t tbl[14];

   // expected on-line bit sequence of one frame, index 0 = start bit
   function automatic logic [NB-1:0] frame(input logic [DW-1:0] d);
      logic [NB-1:0] f;
      f = '0;
      for (int b = 0; b < DW; b++) f[1+b] = d[b];
`ifdef UART_TX_ARB_PARITY_EN
      f[DW+1] = ^d;
`endif
      f[NB-1] = 1'b1;
      return f;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_rr = 0; m_busy = 0; m_tx = 1; m_ack = '0; m_gid = '0; m_armed = 0;
   endtask

   task automatic model_edge();
      int w;
      logic [DW-1:0] d;
      m_ack = '0;
      if (!m_armed) begin m_armed = 1; return; end
      if (!txclk_en) return;
      if (mq.size() > 0) begin m_tx = mq.pop_front(); return; end
      w = -1;
      for (int k = 0; k < NREQ; k++)
         if (w < 0 && req[(m_rr+k)%NREQ]) w = (m_rr+k)%NREQ;
      if (w < 0) begin
         m_tx = 1; m_busy = 0;
      end else begin
         d = req_data[w*DW +: DW];
         for (int b = 0; b < DW; b++) mq.push_back(d[b]);
`ifdef UART_TX_ARB_PARITY_EN
         mq.push_back(^d);
`endif
         mq.push_back(1'b1);
         m_tx = 0; m_busy = 1; m_ack[w] = 1'b1; m_gid = 2'(w); m_rr = (w+1)%NREQ;
      end
   endtask

   // one clock: advance model at the edge, compare 1 time unit later
   task automatic cyc();
      logic t;
      @(posedge clk_50m);
      t = txclk_en && !rst;
      if (rst) model_reset(); else model_edge();
      #1;
      chk("outputs{tx,busy,ack,gid}", {56'd0, tx, busy, ack, grant_id}, {56'd0, m_tx, m_busy, m_ack, m_gid});
      for (int i = 0; i < NREQ; i++) if (ack[i]) grant_log.push_back(i);
      if (t && tick_n < 64) begin tick_vec[tick_n] = tx; tick_n++; end
      if (auto_drop) req = req & ~m_ack;
   endtask

   task automatic run(input int ticks, input int per);
      for (int t = 0; t < ticks; t++)
         for (int c = 0; c < per; c++) begin
            txclk_en = (c == per-1);
            cyc();
         end
      txclk_en = 0;
   endtask

   task automatic clr_obs();
      grant_log.delete(); tick_n = 0; tick_vec = '0;
   endtask

   task automatic do_reset();
      rst = 1; req = '0; txclk_en = 0; auto_drop = 0;
      repeat (3) cyc();
      rst = 0;
      repeat (2) cyc();
      clr_obs();
   endtask

   initial begin
      #10000000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      // ---- reset state + table (includes raise/drop of req[3] with no tick)
      do_reset();
      chk("reset_state", {60'd0, tx, busy, grant_id}, {60'd0, 1'b1, 1'b0, 2'd0});
      tbl[0]  = '{4'b1000, 8'h00, 8'hAA, 1'b0, 1'b1, 1'b0, 4'h0, 2'd0};
      tbl[1]  = '{4'b0000, 8'h00, 8'hAA, 1'b0, 1'b1, 1'b0, 4'h0, 2'd0};
      tbl[2]  = '{4'b0000, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 4'h0, 2'd0};
      tbl[3]  = '{4'b0001, 8'h55, 8'h00, 1'b0, 1'b1, 1'b0, 4'h0, 2'd0};
      tbl[4]  = '{4'b0001, 8'h55, 8'h00, 1'b1, 1'b0, 1'b1, 4'h1, 2'd0};
      tbl[5]  = '{4'b0000, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 4'h0, 2'd0};
      tbl[6]  = '{4'b0000, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b1, 4'h0, 2'd0};
      tbl[7]  = '{4'b0000, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, 4'h0, 2'd0};
      tbl[8]  = '{4'b0000, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b1, 4'h0, 2'd0};
      tbl[9]  = '{4'b0000, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, 4'h0, 2'd0};
      tbl[10] = '{4'b0000, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b1, 4'h0, 2'd0};
      tbl[11] = '{4'b0000, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, 4'h0, 2'd0};
      tbl[12] = '{4'b0000, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b1, 4'h0, 2'd0};
      tbl[13] = '{4'b0000, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, 4'h0, 2'd0};
      for (int n = 0; n < 14; n++) begin
         req = tbl[n].r;
         req_data[7:0]   = tbl[n].d0;
         req_data[31:24] = tbl[n].d3;
         txclk_en = tbl[n].tk;
         cyc();
         chk($sformatf("tbl[%0d]", n), {56'd0, tx, busy, ack, grant_id},
             {56'd0, tbl[n].etx, tbl[n].ebusy, tbl[n].eack, tbl[n].egid});
      end
      txclk_en = 0;
      run(NB, 1);

      // ---- 1: single 0x55 frame at the real baud spacing
      do_reset();
      auto_drop = 1;
      req_data[7:0] = 8'h55; req = 4'b0001;
      run(NB+2, 434);
      chk("t1_bits", {{(62-NB){1'b0}}, tick_vec[NB+1:0]}, {{(62-NB){1'b0}}, 2'b11, frame(8'h55)});
      chk("t1_ack_count", grant_log.size(), 1);
      chk("t1_ack_id", grant_log.size() > 0 ? grant_log[0] : -1, 0);
      chk("t1_idle", {62'd0, busy, tx}, {62'd0, 1'b0, 1'b1});

      // ---- 2: simultaneous req[1], req[2] -> back-to-back frames
      do_reset();
      auto_drop = 1;
      req_data[15:8] = 8'hA1; req_data[23:16] = 8'h3C; req = 4'b0110;
      run(2*NB+2, 3);
      chk("t2_bits", {{(62-2*NB){1'b0}}, tick_vec[2*NB+1:0]},
          {{(62-2*NB){1'b0}}, 2'b11, frame(8'h3C), frame(8'hA1)});
      chk("t2_order", {32'(grant_log.size()), grant_log.size() > 1 ? grant_log[0]*16 + grant_log[1] : -1},
          {32'd2, 32'h12});

      // ---- 3: all four held high for 8 frames
      do_reset();
      req_data = $urandom; req = 4'hF;
      run(8*NB, 2);
      chk("t3_count", grant_log.size(), 8);
      for (int k = 0; k < 8; k++)
         chk($sformatf("t3_grant[%0d]", k), grant_log.size() > k ? grant_log[k] : -1, k % 4);
      req = '0;
      run(NB+1, 2);

      // ---- 4: reset in DATA bit 3 of 0xF0, req held -> full resend, rr_ptr=0
      do_reset();
      req_data[7:0] = 8'hF0; req_data[15:8] = 8'h5A; req = 4'b0011;
      run(5, 2);
      chk("t4_bit3", {62'd0, busy, tx}, {62'd0, 1'b1, 1'b0});
      rst = 1;
      #1;
      chk("t4_async", {58'd0, tx, busy, ack}, {58'd0, 1'b1, 1'b0, 4'h0});
      repeat (2) cyc();
      rst = 0; txclk_en = 1;
      cyc();
      chk("t4_ignored_tick", {59'd0, busy, ack}, 64'd0);
      txclk_en = 0;
      clr_obs();
      auto_drop = 1;
      run(2*NB+1, 2);
      chk("t4_order", grant_log.size() > 1 ? grant_log[0]*16 + grant_log[1] : -1, 32'h01);
      chk("t4_resend", {{(64-NB){1'b0}}, tick_vec[NB-1:0]}, {{(64-NB){1'b0}}, frame(8'hF0)});

`ifdef UART_TX_ARB_PARITY_EN
      // ---- 6: parity bit
      do_reset();
      auto_drop = 1;
      req_data[7:0] = 8'h07; req = 4'b0001;
      run(NB+1, 2);
      chk("t6_par_07", {63'd0, tick_vec[DW+1]}, 64'd1);
      chk("t6_frame_07", {{(63-NB){1'b0}}, tick_vec[NB:0]}, {{(63-NB){1'b0}}, 1'b1, frame(8'h07)});
      chk("t6_idle", {63'd0, busy}, 64'd0);
      clr_obs();
      req_data[7:0] = 8'h03; req = 4'b0001;
      run(NB+1, 2);
      chk("t6_par_03", {63'd0, tick_vec[DW+1]}, 64'd0);
`endif

      // ---- random traffic against the model
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         txclk_en = ($urandom_range(0, 2) == 0);
         cyc();
         for (int i = 0; i < NREQ; i++) begin
            if (req[i] && m_ack[i]) begin
               if ($urandom_range(0, 1) == 1) req_data[i*DW +: DW] = 8'($urandom);
               else req[i] = 1'b0;
            end else if (!req[i] && $urandom_range(0, 9) == 0) begin
               req_data[i*DW +: DW] = 8'($urandom);
               req[i] = 1'b1;
            end else if (req[i] && $urandom_range(0, 299) == 0) begin
               req[i] = 1'b0;
            end
         end
      end
      req = '0;
      run(NB+1, 1);
      chk("rand_drained", {62'd0, busy, tx}, {62'd0, 1'b0, 1'b1});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
